alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational core ALU between two requesters (e.g. integer pipe and address/branch unit).
//  Arbitrates valid/ready requests round-robin or fixed-priority and registers each result plus ZNCV flags.
//  Returns each result on the winning requester's own response channel; counts grants per requester.
// PARAMETERS
//  DATA_W  32  operand/result width; only 32 is legal (ALU is 32-bit), elaborate-time error otherwise
//  CNT_W   16  width of each saturating grant counter
//  FAIR    1   1 = round-robin between r0/r1; 0 = fixed priority, r0 always wins
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst           in   1       asynchronous, active-high reset
//  r0_valid      in   1       requester 0 has an operation
//  r0_ready      out  1       requester 0 operation accepted this cycle (valid&ready)
//  r0_a, r0_b    in   DATA_W  operands
//  r0_op         in   3       ALU control: 000 add, 001 sub, 010 and, 011 or, 101 slt, others -> result 0
//  r0_rsp_valid  out  1       result for requester 0 held in output register
//  r0_rsp_ready  in   1       requester 0 takes result
//  r0_result     out  DATA_W  registered result
//  r0_flags      out  4       registered {Z,N,C,V}
//  r1_*          --   --      identical set for requester 1
//  cnt_clr       in   1       synchronous clear of both grant counters
//  gnt_cnt0/1    out  CNT_W   grants issued to r0 / r1, saturating at all-ones
//  busy          out  1       result register occupied
// BEHAVIOUR
//  - Reset: all outputs 0; slot empty; owner=0; RR pointer -> r0 has priority; counters 0; pending result dropped.
//  - One result register (slot) with owner bit. slot_free = ~busy | (rx_rsp_valid & rx_rsp_ready of owner).
//  - Grant: among valid requesters, pick by pointer (FAIR=1) or r0 first (FAIR=0); rX_ready=1 only for winner
//    and only when slot_free. Ready is combinational from valids + state; valids must not depend on ready.
//  - Accept cycle N (valid&ready): ALU evaluates granted a/b/op; result+flags+owner captured at edge;
//    rsp_valid of owner high from cycle N+1. Latency 1; throughput 1/cycle when consumer holds rsp_ready=1.
//  - rsp_valid, result, flags stay stable until rsp_ready; other requester's rsp_valid stays 0.
//  - Same-cycle drain and accept allowed (slot_free via drain): new result replaces old, no bubble.
//  - RR pointer: after grant to rX, priority moves to the other requester; unchanged when no grant.
//  - Flags: Z=(result==0); N=result[31]; C=carry-out for add/sub, else 0; V=signed overflow for add/sub, else 0;
//    slt = sign bit of A-B (no overflow correction); illegal op -> result 0, Z=1, N=C=V=0.
//  - State machine: EMPTY -(grant)-> FULL; FULL -(drain & ~grant)-> EMPTY; FULL -(drain & grant)-> FULL (new owner);
//    FULL -(~drain)-> FULL, both readies 0. busy = (state==FULL).
//  - Counters: +1 on each grant, hold at 2^CNT_W-1; cnt_clr with grant same cycle -> granted counter = 1, other 0.
//  - rst asserted mid-transaction: result discarded immediately (async), no response ever issued for it.
// STRUCTURE
//  - Package alu_pkg: ALU op localparams (ALU_ADD..ALU_SLT), flag bit indices (FLG_Z=3..FLG_V=0),
//    slot state encoding (ST_EMPTY, ST_FULL).
//  - Sub-module rr_arb2: 2-way arbiter (req[1:0], fair, ptr, gnt[1:0]); instance of the core ALU for datapath;
//    slot, owner, pointer and counters live in this module.
// TESTING
//  1. Reset mid-FULL: r0 add 5+7 accepted, rst at N+1 -> r0_rsp_valid=0 during/after reset, counters 0.
//  2. Single add: r0 a=0x7FFFFFFF b=1 op=000 -> next cycle r0_result=0x80000000, flags N=1,V=1,Z=0,C=0.
//  3. Both valid continuously, FAIR=1, rsp_ready=1 -> grants alternate r0,r1,r0,r1; gnt_cnt0=gnt_cnt1 after 2k cycles.
//  4. Backpressure: r1 sub 3-3 accepted, r1_rsp_ready=0 for 4 cycles -> result 0, Z=1, C=1 held stable,
//     r0_ready=0 throughout, r0 granted the cycle r1_rsp_ready rises.
//  5. FAIR=0, both valid -> r1 never granted while r0_valid=1; illegal op 111 from r0 -> result 0, flags 4'b1000.
//  6. Counter saturation (CNT_W=2): 5 grants to r0 -> gnt_cnt0=3; cnt_clr with grant -> gnt_cnt0=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter: op codes,
// flag bit positions, slot state encoding and the registered response payload.
package alu_pkg;

    localparam int unsigned ALU_W = 32;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned FLG_W = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [OP_W-1:0] ALU_SLT = 3'b101;

    localparam int unsigned FLG_Z = 3;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic [FLG_W-1:0] flags;
    } alu_rsp_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester's operation channel plus its response channel.
interface alu_share_arbiter_if import alu_pkg::*; #(
    parameter int unsigned DATA_W = 32
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] result;
    logic [FLG_W-1:0]  flags;

    modport master (output valid, a, b, op, rsp_ready,
                    input  ready, rsp_valid, result, flags);
    modport slave  (input  valid, a, b, op, rsp_ready,
                    output ready, rsp_valid, result, flags);
endinterface

// File: rtl/alu_core.sv
// Combinational 32-bit ALU producing result and {Z,N,C,V}.
module alu_core import alu_pkg::*; (
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [OP_W-1:0]  op,
    output alu_rsp_t         rsp_c
);
    logic [ALU_W:0] sum;
    logic [ALU_W:0] diff;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} + {1'b0, ~b} + (ALU_W+1)'(1);
        rsp_c = '0;
        case (op)
            ALU_ADD: begin
                rsp_c.result       = sum[ALU_W-1:0];
                rsp_c.flags[FLG_C] = sum[ALU_W];
                rsp_c.flags[FLG_V] = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
            end
            ALU_SUB: begin
                rsp_c.result       = diff[ALU_W-1:0];
                rsp_c.flags[FLG_C] = diff[ALU_W];
                rsp_c.flags[FLG_V] = (a[ALU_W-1] != b[ALU_W-1]) && (diff[ALU_W-1] != a[ALU_W-1]);
            end
            ALU_AND: rsp_c.result = a & b;
            ALU_OR:  rsp_c.result = a | b;
            // slt takes the raw sign of a-b, no overflow correction
            ALU_SLT: rsp_c.result = ALU_W'(diff[ALU_W-1]);
            default: rsp_c.result = '0;
        endcase
        rsp_c.flags[FLG_Z] = (rsp_c.result == '0);
        rsp_c.flags[FLG_N] = rsp_c.result[ALU_W-1];
    end
endmodule

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin from ptr when fair, otherwise req[0] always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       fair,
    input  logic       ptr,
    output logic [1:0] gnt_c
);
    always_comb begin
        gnt_c = '0;
        if (fair && ptr) begin
            gnt_c[1] = req[1];
            gnt_c[0] = req[0] & ~req[1];
        end else begin
            gnt_c[0] = req[0];
            gnt_c[1] = req[1] & ~req[0];
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters through a single registered result slot,
// returning each result on the winner's response channel and counting grants.
module alu_share_arbiter import alu_pkg::*; #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned FAIR   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   r0,
    alu_share_arbiter_if.slave   r1,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     gnt_cnt0,
    output logic [CNT_W-1:0]     gnt_cnt1,
    output logic                 busy
);
    if (DATA_W != ALU_W) begin : g_bad_width
        $error("alu_share_arbiter: DATA_W must be 32");
    end

    slot_state_e      state_q, state_d;
    logic             owner_q;
    logic             ptr_q;
    logic [1:0]       rv_q;
    alu_rsp_t         rsp_q;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    logic             drain_c, slot_free_c, grant_c;
    logic [1:0]       req_c, gnt_c;
    logic [ALU_W-1:0] alu_a_c, alu_b_c;
    logic [OP_W-1:0]  alu_op_c;
    alu_rsp_t         alu_rsp_c;

    // A draining slot is free in the same cycle, so accepts run back to back.
    assign drain_c     = (state_q == ST_FULL) && (owner_q ? r1.rsp_ready : r0.rsp_ready);
    assign slot_free_c = (state_q == ST_EMPTY) || drain_c;
    assign req_c       = {r1.valid, r0.valid} & {2{slot_free_c}};
    assign grant_c     = |gnt_c;

    rr_arb2 u_arb (
        .req   (req_c),
        .fair  (FAIR != 0),
        .ptr   (ptr_q),
        .gnt_c (gnt_c)
    );

    assign alu_a_c  = gnt_c[1] ? r1.a  : r0.a;
    assign alu_b_c  = gnt_c[1] ? r1.b  : r0.b;
    assign alu_op_c = gnt_c[1] ? r1.op : r0.op;

    alu_core u_alu (
        .a     (alu_a_c),
        .b     (alu_b_c),
        .op    (alu_op_c),
        .rsp_c (alu_rsp_c)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (grant_c)             state_d = ST_FULL;
            ST_FULL:  if (drain_c && !grant_c) state_d = ST_EMPTY;
            default:                           state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            rv_q    <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant_c) begin
                owner_q <= gnt_c[1];
                ptr_q   <= gnt_c[0];
                rv_q    <= gnt_c;
                rsp_q   <= alu_rsp_c;
            end else if (drain_c) begin
                rv_q    <= '0;
            end
        end
    end

    // Saturating grant counters; a clear coinciding with a grant leaves that grant counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (cnt_clr) begin
            cnt0_q <= CNT_W'(gnt_c[0]);
            cnt1_q <= CNT_W'(gnt_c[1]);
        end else begin
            if (gnt_c[0] && (cnt0_q != {CNT_W{1'b1}})) cnt0_q <= cnt0_q + CNT_W'(1);
            if (gnt_c[1] && (cnt1_q != {CNT_W{1'b1}})) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign r0.ready     = gnt_c[0];
    assign r1.ready     = gnt_c[1];
    assign r0.rsp_valid = rv_q[0];
    assign r1.rsp_valid = rv_q[1];
    assign r0.result    = rsp_q.result;
    assign r1.result    = rsp_q.result;
    assign r0.flags     = rsp_q.flags;
    assign r1.flags     = rsp_q.flags;
    assign gnt_cnt0     = cnt0_q;
    assign gnt_cnt1     = cnt1_q;
    assign busy         = (state_q == ST_FULL);
endmodule
